// File: rtl/thermostat_pkg.sv
// Shared definitions for the thermostat controller: FSM state encoding and counter sizing.
// Optional feature macro used by the top: THERMO_MIN_RUN_EN.
package thermostat_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHeat = 2'd1,
        StCool = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] CTRL_IDLE = 2'd0;
    localparam logic [1:0] CTRL_HEAT = 2'd1;
    localparam logic [1:0] CTRL_COOL = 2'd2;

    // Bits needed for a counter that runs 0 .. max_val-1.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/button_pulse.sv
// Push-button conditioner: 2-flop synchronizer, debouncer and rising-edge pulse generator.
module button_pulse
    import thermostat_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_button,
    output logic o_pulse
);

    localparam int unsigned     CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CntLast = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CntLast) begin
                r_level <= r_sync2;
                r_pulse <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/thermostat_controller.sv
// Hysteresis thermostat with debounced setpoint buttons and stale-sample watchdog.
// Define THERMO_MIN_RUN_EN to enforce a minimum HEAT/COOL run time before returning to IDLE.
module thermostat_controller
    import thermostat_pkg::*;
#(
    parameter int unsigned SP_DEFAULT      = 22,
    parameter int unsigned SP_MIN          = 10,
    parameter int unsigned SP_MAX          = 35,
    parameter int unsigned HYST            = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MIN_RUN_CYCLES  = 100000000,
    parameter int unsigned STALE_CYCLES    = 200000000
) (
    input  logic       main_clk,
    input  logic       reset,
    input  logic [7:0] temp_c,
    input  logic       temp_valid,
    input  logic       buttonUp,
    input  logic       buttonDown,
    output logic [7:0] setpoint_c,
    output logic       heat_on,
    output logic       cool_on,
    output logic [1:0] ctrl_state,
    output logic       temp_stale
);

    localparam int unsigned   SW        = cnt_width(STALE_CYCLES);
    localparam logic [SW-1:0] StaleLast = SW'(STALE_CYCLES - 1);
    localparam logic [8:0]    Hyst9     = 9'(HYST);

    logic          w_up;
    logic          w_down;
    logic [7:0]    r_setpoint;
    logic [7:0]    r_temp;
    logic          r_seen;
    logic [SW-1:0] r_stale_cnt;
    logic          r_stale;
    logic          w_stale_expire;
    logic          w_force_idle;
    logic          w_run_done;
    ctrl_state_e   r_state;
    logic          r_heat;
    logic          r_cool;
    logic [8:0]    w_temp9;
    logic [8:0]    w_sp9;
    logic [8:0]    w_lo9;
    logic [8:0]    w_hi9;

    button_pulse #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_up (
        .i_clk    (main_clk),
        .i_reset  (reset),
        .i_button (buttonUp),
        .o_pulse  (w_up)
    );

    button_pulse #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_down (
        .i_clk    (main_clk),
        .i_reset  (reset),
        .i_button (buttonDown),
        .o_pulse  (w_down)
    );

    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_setpoint <= 8'(SP_DEFAULT);
        end else if (w_up && !w_down && (r_setpoint < 8'(SP_MAX))) begin
            r_setpoint <= r_setpoint + 8'd1;
        end else if (w_down && !w_up && (r_setpoint > 8'(SP_MIN))) begin
            r_setpoint <= r_setpoint - 8'd1;
        end
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_temp <= 8'd0;
            r_seen <= 1'b0;
        end else if (temp_valid) begin
            r_temp <= temp_c;
            r_seen <= 1'b1;
        end
    end

    // A sample arriving on the expiry cycle wins over the watchdog.
    assign w_stale_expire = !temp_valid && !r_stale && (r_stale_cnt == StaleLast);
    assign w_force_idle   = r_stale || w_stale_expire;

    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_stale_cnt <= '0;
            r_stale     <= 1'b0;
        end else if (temp_valid) begin
            r_stale_cnt <= '0;
            r_stale     <= 1'b0;
        end else if (w_stale_expire) begin
            r_stale_cnt <= '0;
            r_stale     <= 1'b1;
        end else if (!r_stale) begin
            r_stale_cnt <= r_stale_cnt + 1'b1;
        end
    end

    // Unsigned 9-bit thresholds; the lower one floors at 0, where "temp < 0" is never true anyway.
    assign w_temp9 = {1'b0, r_temp};
    assign w_sp9   = {1'b0, r_setpoint};
    assign w_lo9   = (w_sp9 < Hyst9) ? 9'd0 : (w_sp9 - Hyst9);
    assign w_hi9   = w_sp9 + Hyst9;

`ifdef THERMO_MIN_RUN_EN
    localparam int unsigned   RW      = cnt_width(MIN_RUN_CYCLES);
    localparam logic [RW-1:0] RunLast = RW'(MIN_RUN_CYCLES - 1);

    logic [RW-1:0] r_run_cnt;

    // Cleared while IDLE; HEAT and COOL are always separated by IDLE.
    always_ff @(posedge main_clk) begin
        if (reset || (r_state == StIdle)) begin
            r_run_cnt <= '0;
        end else if (r_run_cnt != RunLast) begin
            r_run_cnt <= r_run_cnt + 1'b1;
        end
    end

    assign w_run_done = (r_run_cnt == RunLast);
`else
    assign w_run_done = (MIN_RUN_CYCLES == 0) | 1'b1;
`endif

    always_ff @(posedge main_clk) begin
        if (reset || w_force_idle) begin
            r_state <= StIdle;
            r_heat  <= 1'b0;
            r_cool  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (r_seen && (w_temp9 < w_lo9)) begin
                        r_state <= StHeat;
                        r_heat  <= 1'b1;
                    end else if (r_seen && (w_temp9 > w_hi9)) begin
                        r_state <= StCool;
                        r_cool  <= 1'b1;
                    end
                end
                StHeat: begin
                    if ((w_temp9 >= w_sp9) && w_run_done) begin
                        r_state <= StIdle;
                        r_heat  <= 1'b0;
                    end
                end
                StCool: begin
                    if ((w_temp9 <= w_sp9) && w_run_done) begin
                        r_state <= StIdle;
                        r_cool  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_heat  <= 1'b0;
                    r_cool  <= 1'b0;
                end
            endcase
        end
    end

    assign setpoint_c = r_setpoint;
    assign heat_on    = r_heat;
    assign cool_on    = r_cool;
    assign ctrl_state = r_state;
    assign temp_stale = r_stale;

endmodule

// File: tb/tb_thermostat_controller.sv
// Scoreboard bench for thermostat_controller: directed stimulus queues expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_thermostat_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] temp_c = 8'd0;
    logic       temp_valid = 1'b0;
    logic       buttonUp = 1'b0;
    logic       buttonDown = 1'b0;
    logic [7:0] setpoint_c;
    logic       heat_on;
    logic       cool_on;
    logic [1:0] ctrl_state;
    logic       temp_stale;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        bit         full;
        logic [7:0] sp;
        logic [1:0] st;
        logic       stale;
    } exp_t;

    exp_t q[$];

    thermostat_controller #(
        .SP_DEFAULT      (22),
        .SP_MIN          (10),
        .SP_MAX          (35),
        .HYST            (1),
        .DEBOUNCE_CYCLES (4),
        .MIN_RUN_CYCLES  (10),
        .STALE_CYCLES    (50)
    ) dut (
        .main_clk   (clk),
        .reset      (reset),
        .temp_c     (temp_c),
        .temp_valid (temp_valid),
        .buttonUp   (buttonUp),
        .buttonDown (buttonDown),
        .setpoint_c (setpoint_c),
        .heat_on    (heat_on),
        .cool_on    (cool_on),
        .ctrl_state (ctrl_state),
        .temp_stale (temp_stale)
    );

    always #5 clk = ~clk;

    // Monitor: the DUT outputs are presented every cycle; compare pending expectations.
    always @(negedge clk) begin
        exp_t e;
        logic [4:0] act;
        logic [4:0] req;
        total++;
        if (heat_on && cool_on) begin
            bad++;
            $display("FAIL excl: heat_on=%0b cool_on=%0b required not both 1", heat_on, cool_on);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (setpoint_c !== e.sp) begin
                bad++;
                $display("FAIL %s setpoint: got %0d want %0d", e.name, setpoint_c, e.sp);
            end
            if (e.full) begin
                total++;
                act = {ctrl_state, heat_on, cool_on, temp_stale};
                req = {e.st, e.st == 2'd1, e.st == 2'd2, e.stale};
                if (act !== req) begin
                    bad++;
                    $display("FAIL %s {state,heat,cool,stale}: got %b want %b", e.name, act, req);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_sp(input string n, input logic [7:0] sp);
        exp_t e;
        e.name = n; e.full = 1'b0; e.sp = sp; e.st = 2'd0; e.stale = 1'b0;
        q.push_back(e);
    endtask

    task automatic exp_all(input string n, input logic [7:0] sp, input logic [1:0] st,
                           input logic stale);
        exp_t e;
        e.name = n; e.full = 1'b1; e.sp = sp; e.st = st; e.stale = stale;
        q.push_back(e);
    endtask

    task automatic press(input bit up, input bit dn, input int hold);
        buttonUp = up;
        buttonDown = dn;
        tick(hold);
        buttonUp = 1'b0;
        buttonDown = 1'b0;
        tick(10);
    endtask

    task automatic send(input logic [7:0] t);
        temp_c = t;
        temp_valid = 1'b1;
        tick(1);
        temp_valid = 1'b0;
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        exp_all("reset", 8'd22, 2'd0, 1'b0);

        // Buttons: clean press, glitches, long hold.
        press(1, 0, 6);  exp_sp("up_press", 8'd23);
        press(1, 0, 3);  exp_sp("up_glitch", 8'd23);
        press(1, 0, 20); exp_sp("up_long_hold", 8'd24);
        press(0, 1, 3);  exp_sp("down_glitch", 8'd24);
        for (int i = 0; i < 11; i++) press(1, 0, 6);
        exp_sp("up_to_max", 8'd35);
        for (int i = 0; i < 3; i++) press(1, 0, 6);
        exp_sp("sat_max", 8'd35);
        for (int i = 0; i < 25; i++) press(0, 1, 6);
        exp_sp("down_to_min", 8'd10);
        press(0, 1, 6);  exp_sp("sat_min", 8'd10);
        press(1, 0, 6);  exp_sp("up_from_min", 8'd11);
        press(1, 1, 6);  exp_sp("simultaneous", 8'd11);
        for (int i = 0; i < 11; i++) press(1, 0, 6);
        exp_sp("back_to_22", 8'd22);

        // Heating with hysteresis.
        send(8'd20); exp_all("t20_latency", 8'd22, 2'd0, 1'b0);
        tick(1);     exp_all("t20_heat", 8'd22, 2'd1, 1'b0);
        send(8'd21); tick(1); exp_all("t21_stay_heat", 8'd22, 2'd1, 1'b0);
        send(8'd22); exp_all("t22_latency", 8'd22, 2'd1, 1'b0);
        tick(1);     exp_all("t22_idle", 8'd22, 2'd0, 1'b0);

        // Cooling, then swing to heat through IDLE.
        send(8'd24); tick(1); exp_all("t24_cool", 8'd22, 2'd2, 1'b0);
        send(8'd19); exp_all("t19_latency", 8'd22, 2'd2, 1'b0);
        tick(1);     exp_all("t19_idle", 8'd22, 2'd0, 1'b0);
        tick(1);     exp_all("t19_heat", 8'd22, 2'd1, 1'b0);

        // Stale watchdog: 19 latched 2 cycles ago, expiry 50 cycles after the latch.
        tick(47);    exp_all("stale_edge_minus1", 8'd22, 2'd1, 1'b0);
        tick(1);     exp_all("stale_expire", 8'd22, 2'd0, 1'b1);
        tick(5);     exp_all("stale_held", 8'd22, 2'd0, 1'b1);
        send(8'd20); exp_all("stale_clear", 8'd22, 2'd0, 1'b0);
        tick(1);     exp_all("stale_reheat", 8'd22, 2'd1, 1'b0);

        // Sample coincident with the expiry cycle wins.
        tick(48);    exp_all("coinc_before", 8'd22, 2'd1, 1'b0);
        send(8'd20); exp_all("coinc_valid_wins", 8'd22, 2'd1, 1'b0);
        tick(49);    exp_all("coinc_restart", 8'd22, 2'd1, 1'b0);
        tick(1);     exp_all("coinc_expire", 8'd22, 2'd0, 1'b1);

        // Reset during COOL.
        press(1, 0, 6); exp_sp("pre_reset_up", 8'd23);
        send(8'd25); exp_all("t25_latency", 8'd23, 2'd0, 1'b0);
        tick(1);     exp_all("t25_cool", 8'd23, 2'd2, 1'b0);
        reset = 1'b1;
        tick(1);     exp_all("reset_in_cool", 8'd22, 2'd0, 1'b0);
        reset = 1'b0;
        temp_c = 8'd30;
        tick(3);     exp_all("no_sample_idle", 8'd22, 2'd0, 1'b0);
        send(8'd30); tick(1); exp_all("post_reset_cool", 8'd22, 2'd2, 1'b0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        tick(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/thermostat_controller.md
THERMOSTAT_CONTROLLER -- requirements
Module: thermostat_controller

Interface
REQ-001 SHALL provide parameter SP_DEFAULT, 22, setpoint loaded at reset (deg C).
REQ-002 SHALL provide parameter SP_MIN, 10, lowest allowed setpoint.
REQ-003 SHALL provide parameter SP_MAX, 35, highest allowed setpoint.
REQ-004 SHALL provide parameter HYST, 1, hysteresis band (deg C), 0..7.
REQ-005 SHALL provide parameter DEBOUNCE_CYCLES, 1000000, stable-input cycles required per button.
REQ-006 SHALL provide parameter MIN_RUN_CYCLES, 100000000, minimum heat/cool run time.
REQ-007 SHALL provide parameter STALE_CYCLES, 200000000, max cycles between temperature samples.
REQ-008 SHALL have port main_clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-009 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-010 SHALL have port temp_c  in  8  unsigned Celsius sample, 0..127.
REQ-011 SHALL have port temp_valid  in  1  one-cycle strobe qualifying temp_c.
REQ-012 SHALL have ports buttonUp, buttonDown  in  1 each  raw asynchronous push-buttons.
REQ-013 SHALL have port setpoint_c  out  8  current setpoint.
REQ-014 SHALL have ports heat_on, cool_on  out  1 each  actuator demands.
REQ-015 SHALL have port ctrl_state  out  2  FSM state (IDLE=0, HEAT=1, COOL=2).
REQ-016 SHALL have port temp_stale  out  1  no sample within STALE_CYCLES.

Function
REQ-017 Each button SHALL pass a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive equal samples; a debounced 0->1 edge SHALL yield one single-cycle press pulse.
REQ-018 Up pulse SHALL increment setpoint_c saturating at SP_MAX; down pulse SHALL decrement saturating at SP_MIN; simultaneous up and down pulses SHALL leave setpoint unchanged.
REQ-019 temp_c SHALL be latched on temp_valid; before first valid sample after reset, FSM SHALL stay IDLE.
REQ-020 Comparisons SHALL use 9-bit signed-safe arithmetic; setpoint-HYST and setpoint+HYST SHALL never wrap.
REQ-021 IDLE->HEAT when latched temp < setpoint-HYST; IDLE->COOL when latched temp > setpoint+HYST; otherwise stay.
REQ-022 HEAT->IDLE when latched temp >= setpoint; COOL->IDLE when latched temp <= setpoint; HEAT<->COOL direct transition SHALL NOT occur.
REQ-023 FSM SHALL evaluate every cycle; state change SHALL be visible one cycle after the latched temp or setpoint that causes it.
REQ-024 heat_on SHALL equal (state==HEAT), cool_on (state==COOL), both registered; never both 1.
REQ-025 Stale counter SHALL clear on temp_valid; on reaching STALE_CYCLES temp_stale=1, FSM forced IDLE, held until next temp_valid.
REQ-026 temp_valid coincident with stale expiry SHALL win: counter clears, temp_stale stays 0.

Reset
REQ-027 Reset SHALL set setpoint_c=SP_DEFAULT, ctrl_state=IDLE, heat_on=0, cool_on=0, temp_stale=0, all counters 0, sample-seen flag 0, debounced levels 0.
REQ-028 Reset asserted mid-HEAT/COOL SHALL drop actuator outputs the cycle after reset is sampled.

Configuration
REQ-029 Macro THERMO_MIN_RUN_EN defined: HEAT/COOL->IDLE exit SHALL additionally require MIN_RUN_CYCLES cycles elapsed in that state; stale forcing and reset override it.
REQ-030 Macro undefined: no run timer instantiated; exits per REQ-022 only.

Structure
REQ-031 Package thermostat_pkg SHALL hold the ctrl_state encoding constants and counter-width helper function.
REQ-032 Sub-module button_pulse (synchronizer, debouncer, edge detect) SHALL be instantiated once per button.

Verification (DEBOUNCE_CYCLES=4, MIN_RUN_CYCLES=10, STALE_CYCLES=50, HYST=1)
REQ-033 Reset, then buttonUp held 6 cycles -> setpoint_c 22->23 exactly once; 3-cycle glitch -> no change.
REQ-034 Setpoint at 35, three up presses -> stays 35; at 10, down press -> stays 10; simultaneous press -> unchanged.
REQ-035 Setpoint 22, temp 20 valid -> HEAT next cycle, heat_on=1; temp 21 -> stays HEAT; temp 22 -> IDLE (after 10 cycles if THERMO_MIN_RUN_EN).
REQ-036 Setpoint 22, temp 24 -> COOL; temp 19 while COOL -> IDLE then HEAT, never heat_on&cool_on.
REQ-037 HEAT active, no temp_valid for 50 cycles -> temp_stale=1, heat_on=0; next valid temp 20 -> temp_stale=0, HEAT.
REQ-038 Reset pulse during COOL -> cool_on=0, setpoint_c=22 next cycle.
